// File: rtl/hps_addr_seq_pkg.sv
// Shared register offsets, CTRL/status bit positions and FSM states for the
// HPS address sequencer.
package hps_addr_seq_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_BASE   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STRIDE = 2'd3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_IRQ_EN  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/hps_addr_seq_regs.sv
// Avalon-MM decode, BASE/COUNT/STRIDE/irq_en register file and zero-wait read mux.
// Register writes land on the next edge; readdata is combinational from address.
module hps_addr_seq_regs
   import hps_addr_seq_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic              busy_i,
   input  logic              done_i,
   input  logic              aborted_i,
   output logic [ADDR_W-1:0] base_o,
   output logic [CNT_W-1:0]  count_o,
   output logic [ADDR_W-1:0] stride_o,
   output logic              irq_en_o,
   output logic              ctrl_wr_o,
   output logic              start_o,
   output logic              abort_o
);

   logic              wr_en;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  count_q;
   logic [ADDR_W-1:0] stride_q;
   logic              irq_en_q;
   logic              unused_wdat;

   assign wr_en       = chipselect & ~write_n;
   assign ctrl_wr_o   = wr_en && (address == REG_CTRL);
   assign start_o     = ctrl_wr_o & writedata[CTRL_START];
   assign abort_o     = ctrl_wr_o & writedata[CTRL_ABORT];
   assign unused_wdat = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q   <= '0;
         count_q  <= '0;
         stride_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
         irq_en_q <= 1'b0;
      end else if (wr_en) begin
         case (address)
            REG_CTRL:   irq_en_q <= writedata[CTRL_IRQ_EN];
            REG_BASE:   base_q   <= writedata[ADDR_W-1:0];
            REG_COUNT:  count_q  <= writedata[CNT_W-1:0];
            REG_STRIDE: stride_q <= writedata[ADDR_W-1:0];
            default:    ;
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         REG_CTRL:   readdata = {28'b0, irq_en_q, aborted_i, done_i, busy_i};
         REG_BASE:   readdata[ADDR_W-1:0] = base_q;
         REG_COUNT:  readdata[CNT_W-1:0]  = count_q;
         REG_STRIDE: readdata[ADDR_W-1:0] = stride_q;
         default:    readdata = '0;
      endcase
   end

   assign base_o   = base_q;
   assign count_o  = count_q;
   assign stride_o = stride_q;
   assign irq_en_o = irq_en_q;

endmodule

// File: rtl/hps_addr_sequencer.sv
// HPS-programmable address sequencer: one address per valid/ready beat from BASE by STRIDE.
// First address one cycle after start; out_addr/out_valid hold while out_ready is low.
module hps_addr_sequencer
   import hps_addr_seq_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              irq
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] base, stride;
   logic [CNT_W-1:0]  count;
   logic              irq_en, ctrl_wr, start, abort;

   seq_state_t        state_q;
   logic [ADDR_W-1:0] addr_q, wrk_stride_q;
   logic [CNT_W-1:0]  remain_q;
   logic              valid_q, done_q, aborted_q;
   logic              beat;

   hps_addr_seq_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_regs (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .busy_i     (state_q == ST_RUN),
      .done_i     (done_q),
      .aborted_i  (aborted_q),
      .base_o     (base),
      .count_o    (count),
      .stride_o   (stride),
      .irq_en_o   (irq_en),
      .ctrl_wr_o  (ctrl_wr),
      .start_o    (start),
      .abort_o    (abort)
   );

   assign beat = valid_q & out_ready;

   // Status clears on any CTRL write; the FSM's own set below overrides that clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         wrk_stride_q <= '0;
         remain_q     <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (abort) begin
                  aborted_q <= 1'b1;
               end else if (start) begin
                  if (count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q       <= base;
                     wrk_stride_q <= stride;
                     remain_q     <= count;
                     valid_q      <= 1'b1;
                     state_q      <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (beat) begin
                  addr_q   <= addr_q + wrk_stride_q;
                  remain_q <= remain_q - CNT_ONE;
               end
               if (abort) begin
                  aborted_q <= 1'b1;
                  valid_q   <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (beat && remain_q == CNT_ONE) begin
                  done_q  <= 1'b1;
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_addr  = addr_q;
   assign out_valid = valid_q;
   assign irq       = done_q & irq_en;

endmodule

// File: tb/tb_hps_addr_sequencer.sv
// Randomized bench for hps_addr_sequencer: expected address lists are computed as
// BASE + i*STRIDE (mod 256) and drained against the DUT's valid/ready handshakes.
module tb_hps_addr_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  out_addr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   hps_addr_sequencer #(.ADDR_W(8), .CNT_W(9)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_addr   (out_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      address = a;
      #1;
      chk(tag, readdata, exp);
      address = 2'd0;
   endtask

   function automatic logic [31:0] ctrl_word(input bit ien, input bit abt, input bit dn, input bit bsy);
      return {28'b0, ien, abt, dn, bsy};
   endfunction

   // Program one sequence, start it, and drain it with a random stall rate.
   // abort_at >= 0 issues an abort once that many beats have been accepted.
   task automatic run_seq(input logic [7:0] b, input logic [7:0] s, input logic [8:0] c,
                          input bit ien, input int stall_pct, input int abort_at);
      logic [7:0] q[$];
      int  beats;
      int  cyc;
      bit  aborted;
      bit  rdy;
      q.delete();
      for (int i = 0; i < int'(c); i++) q.push_back(8'(int'(b) + i * int'(s)));
      wr(2'd1, {24'b0, b});
      wr(2'd3, {24'b0, s});
      wr(2'd2, {23'b0, c});
      wr(2'd0, ctrl_word(ien, 1'b0, 1'b0, 1'b1));
      if (c == 9'd0) begin
         chk("zero_cnt_valid", {31'b0, out_valid}, 32'd0);
         rd(2'd0, ctrl_word(ien, 1'b0, 1'b1, 1'b0), "zero_cnt_ctrl");
         chk("zero_cnt_irq", {31'b0, irq}, {31'b0, ien});
         tick();
         chk("zero_cnt_valid_later", {31'b0, out_valid}, 32'd0);
         return;
      end
      beats   = 0;
      cyc     = 0;
      aborted = 1'b0;
      while (q.size() > 0 && cyc < 4000) begin
         chk("run_valid", {31'b0, out_valid}, 32'd1);
         chk("run_addr", {24'b0, out_addr}, {24'b0, q[0]});
         rd(2'd0, ctrl_word(ien, 1'b0, 1'b0, 1'b1), "run_ctrl");
         if (abort_at >= 0 && beats == abort_at) begin
            out_ready = 1'($urandom_range(1));
            wr(2'd0, ctrl_word(ien, 1'b0, 1'b1, 1'b0));
            q.delete();
            aborted = 1'b1;
         end else begin
            rdy = (int'($urandom_range(99)) >= stall_pct);
            out_ready = rdy;
            tick();
            if (rdy) begin
               void'(q.pop_front());
               beats++;
            end
         end
         cyc++;
      end
      if (cyc >= 4000) chk("timeout", 32'd1, 32'd0);
      chk("end_valid", {31'b0, out_valid}, 32'd0);
      rd(2'd0, aborted ? ctrl_word(ien, 1'b1, 1'b0, 1'b0) : ctrl_word(ien, 1'b0, 1'b1, 1'b0), "end_ctrl");
      chk("end_irq", {31'b0, irq}, aborted ? 32'd0 : {31'b0, ien});
      out_ready = 1'b1;
      tick();
      chk("end_valid_later", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int c;
      int abort_at;
      logic [7:0] rb, rs;

      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_addr", {24'b0, out_addr}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      rd(2'd0, 32'd0, "rst_ctrl");
      rd(2'd1, 32'd0, "rst_base");
      rd(2'd2, 32'd0, "rst_count");
      rd(2'd3, 32'd1, "rst_stride");
      @(negedge clk);
      reset = 1'b0;
      tick();

      run_seq(8'h10, 8'd4, 9'd3, 1'b0, 0, -1);
      run_seq(8'hFE, 8'd1, 9'd4, 1'b1, 0, -1);
      run_seq(8'h20, 8'd3, 9'd6, 1'b0, 50, -1);
      run_seq(8'h55, 8'd0, 9'd5, 1'b0, 30, -1);

      run_seq(8'h40, 8'd2, 9'd0, 1'b1, 0, -1);
      wr(2'd0, 32'h8);
      chk("irq_clear", {31'b0, irq}, 32'd0);
      rd(2'd0, 32'h8, "irq_clear_ctrl");

      run_seq(8'h80, 8'd5, 9'd10, 1'b0, 0, 2);
      run_seq(8'h80, 8'd5, 9'd10, 1'b0, 0, -1);

      wr(2'd0, 32'h3);
      chk("start_abort_valid", {31'b0, out_valid}, 32'd0);
      rd(2'd0, 32'h4, "start_abort_ctrl");

      wr(2'd1, 32'h33);
      wr(2'd3, 32'h7);
      wr(2'd2, 32'd10);
      wr(2'd0, 32'h9);
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_addr", {24'b0, out_addr}, 32'd0);
      chk("midrst_irq", {31'b0, irq}, 32'd0);
      rd(2'd0, 32'd0, "midrst_ctrl");
      rd(2'd1, 32'd0, "midrst_base");
      rd(2'd3, 32'd1, "midrst_stride");
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("midrst_valid_after", {31'b0, out_valid}, 32'd0);

      run_seq(8'h01, 8'd3, 9'd511, 1'b1, 20, -1);

      for (int n = 0; n < 25; n++) begin
         rb = 8'($urandom);
         rs = 8'($urandom);
         c  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 24));
         abort_at = (c > 0 && $urandom_range(3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
         run_seq(rb, rs, 9'(c), 1'($urandom_range(1)), int'($urandom_range(70)), abort_at);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hps_addr_sequencer.md
# hps_addr_sequencer

Avalon-MM–programmable address sequencer that replaces hand-written HPS address stores for the neural-network weight/activation storage. The HPS programs a base address, count and stride, then writes a start bit; the block emits one 8-bit address per accepted valid/ready beat to the downstream storage. It reports busy, done and abort status through the same slave and raises a level interrupt on completion.

## Interface
- `ADDR_W`, 8, width of generated address; wraps modulo 2^ADDR_W
- `CNT_W`, 9, width of COUNT register; max sequence length is 2^CNT_W−1
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `address`  in  2  Avalon register select
- `chipselect`  in  1  Avalon select
- `write_n`  in  1  Avalon write strobe, active-low
- `writedata`  in  32  Avalon write data
- `readdata`  out  32  Avalon read data, combinational, zero wait states
- `out_addr`  out  ADDR_W  generated address
- `out_valid`  out  1  out_addr is valid
- `out_ready`  in  1  downstream accepts beat
- `irq`  out  1  done & irq_en, level

One clock; reset is asynchronous and active-high.

## Operation
- Register map (write = chipselect & ~write_n):
  - 0 CTRL: write bit0 start, bit1 abort, bit3 irq_en (stored). Any write clears done and aborted. Read {28'b0, irq_en, aborted, done, busy}.
  - 1 BASE[ADDR_W-1:0], 2 COUNT[CNT_W-1:0], 3 STRIDE[ADDR_W-1:0]; reads zero-extended.
- Reset values: BASE 0, COUNT 0, STRIDE 1, irq_en 0, busy/done/aborted 0, out_addr 0, out_valid 0, irq 0.
- FSM states IDLE, RUN.
  - IDLE + start, COUNT≠0: latch BASE/COUNT/STRIDE into working copies; go RUN.
  - IDLE + start, COUNT=0: stay IDLE, set done.
  - RUN: out_valid=1, out_addr=current. On out_valid&out_ready: addr ← addr+STRIDE (mod 2^ADDR_W), remaining−1. Last beat (remaining=1) → IDLE, set done.
  - RUN + abort: → IDLE, set aborted, done stays 0; an in-flight handshake in that cycle is counted but no further beats.
- Start while busy ignored. Same write with start and abort: abort wins; from IDLE it only sets aborted.
- BASE/COUNT/STRIDE writes while busy update the registers but not the running sequence.
- STRIDE 0 legal: repeats same address COUNT times.

## Timing
- Start write in cycle T → busy=1, out_valid=1, out_addr=BASE in T+1.
- Each accepted beat advances out_addr next cycle; out_addr/out_valid stable while out_valid&~out_ready.
- Last beat accepted in cycle L → out_valid=0, busy=0, done=1, irq (if irq_en) in L+1.
- COUNT=0 start in T → done=1 in T+1, out_valid never asserts.
- Abort write in T → out_valid=0, busy=0, aborted=1 in T+1.
- readdata reflects register state in the same cycle as address (readLatency 0).
- Reset asserted mid-sequence: all state to reset values immediately; no further beats.

## Structure
- Package `hps_addr_seq_pkg`: register offsets (CTRL/BASE/COUNT/STRIDE), CTRL bit positions, FSM state enum.
- Optional sub-module `hps_addr_seq_regs` (Avalon decode + register file + read mux); sequencing FSM stays in top.

## Test plan
- BASE=0x10, STRIDE=4, COUNT=3, start, out_ready=1 → addresses 0x10,0x14,0x18 on consecutive cycles, done=1 on 4th cycle, CTRL read=0x2.
- BASE=0xFE, STRIDE=1, COUNT=4 → 0xFE,0xFF,0x00,0x01 (wrap).
- out_ready toggled 1,0,0,1… → out_addr held during stalls; exactly COUNT beats delivered.
- COUNT=0 start → done next cycle, no out_valid; irq_en=1 → irq=1 until CTRL write clears done.
- Abort after 2 of 10 beats → out_valid drops next cycle, CTRL read=0x4; new start runs full sequence from BASE.
- Reset pulse mid-RUN, and start+abort same write → all outputs zero/idle; only aborted set.
